// File: rtl/packet_arbiter.sv
// packet_arbiter: packet-granular round-robin arbiter merging N_PORTS packet
// streams into one registered beat stream (payload_aligner input bundle).
//
// Ports:
//   iClk, iReset       clock, synchronous active-high reset
//   iValid/iSop/iEop   per-port beat qualifiers (N_PORTS bits each)
//   iPacket            per-port data, port i at [i*W +: W]
//   iByte_enable       per-port byte enables, port i at [i*DATA_BYTES +: DATA_BYTES]
//   oReady             combinational per-port accept (grant or stray drain)
//   oValid..oPort      registered output beat and its source port
//   oProto_err         pulse with an owner beat that re-asserted sop mid-packet
//   oDrop_count        saturating count of drained stray beats
module packet_arbiter #(
    parameter int unsigned N_PORTS    = 4,
    parameter int unsigned DATA_BYTES = 8
) (
    input  logic                               iClk,
    input  logic                               iReset,
    input  logic [N_PORTS-1:0]                 iValid,
    input  logic [N_PORTS*DATA_BYTES*8-1:0]    iPacket,
    input  logic [N_PORTS-1:0]                 iSop,
    input  logic [N_PORTS-1:0]                 iEop,
    input  logic [N_PORTS*DATA_BYTES-1:0]      iByte_enable,
    output logic [N_PORTS-1:0]                 oReady,
    output logic                               oValid,
    output logic [DATA_BYTES*8-1:0]            oPacket,
    output logic                               oSop,
    output logic                               oEop,
    output logic [DATA_BYTES-1:0]              oByte_enable,
    output logic [$clog2(N_PORTS)-1:0]         oPort,
    output logic                               oProto_err,
    output logic [15:0]                        oDrop_count
);

    localparam int unsigned W  = DATA_BYTES * 8;
    localparam int unsigned PW = $clog2(N_PORTS);
    localparam int unsigned CW = $clog2(N_PORTS + 1);

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [PW-1:0]       last_q;
    logic [PW-1:0]       owner_q;

    logic [N_PORTS-1:0]  cand;
    logic                found;
    logic [PW-1:0]       winner;
    logic [PW-1:0]       idx;

    logic                xfer;
    logic [PW-1:0]       sel;
    logic [N_PORTS-1:0]  stray;
    logic                proto_err_c;
    logic [CW-1:0]       stray_cnt;
    logic [16:0]         drop_sum;

    // Round-robin search over sop candidates, starting just after the last winner.
    always_comb begin
        cand   = iValid & iSop;
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int unsigned k = 1; k <= N_PORTS; k++) begin
            idx = PW'((32'(last_q) + k) % N_PORTS);
            if (!found && cand[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // State register; last/owner are captured only when ARB grants.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q <= ARB;
            last_q  <= PW'(N_PORTS - 1);
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ARB && found) begin
                last_q  <= winner;
                owner_q <= winner;
            end
        end
    end

    // Next state: a single-beat packet keeps ARB; an owner eop releases the lock.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB: begin
                if (found && !iEop[winner]) begin
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (iValid[owner_q] && iEop[owner_q]) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    // Grant/drain decode. Non-owner beats without sop are accepted and dropped;
    // non-owner sop beats are held off.
    always_comb begin
        oReady      = '0;
        xfer        = 1'b0;
        sel         = owner_q;
        stray       = '0;
        proto_err_c = 1'b0;
        if (!iReset) begin
            stray = iValid & ~iSop;
            if (state_q == ARB) begin
                sel  = winner;
                xfer = found;
            end else begin
                xfer           = iValid[owner_q];
                proto_err_c    = iValid[owner_q] & iSop[owner_q];
                stray[owner_q] = 1'b0;
            end
            oReady = stray;
            if (xfer) begin
                oReady[sel] = 1'b1;
            end
        end
    end

    // Number of beats drained this cycle and the saturated running total.
    always_comb begin
        stray_cnt = '0;
        for (int unsigned k = 0; k < N_PORTS; k++) begin
            stray_cnt = stray_cnt + CW'(stray[k]);
        end
        drop_sum = 17'(oDrop_count) + 17'(stray_cnt);
    end

    // Output beat register; data fields hold when no beat transfers.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            oValid       <= 1'b0;
            oPacket      <= '0;
            oSop         <= 1'b0;
            oEop         <= 1'b0;
            oByte_enable <= '0;
            oPort        <= '0;
            oProto_err   <= 1'b0;
            oDrop_count  <= '0;
        end else begin
            oValid     <= xfer;
            oProto_err <= proto_err_c;
            if (xfer) begin
                oPacket      <= iPacket[32'(sel) * W +: W];
                oSop         <= iSop[sel];
                oEop         <= iEop[sel];
                oByte_enable <= iByte_enable[32'(sel) * DATA_BYTES +: DATA_BYTES];
                oPort        <= sel;
            end
            oDrop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

endmodule

// File: tb/tb_packet_arbiter.sv
// tb_packet_arbiter: directed scenarios plus random traffic for packet_arbiter,
// checked every cycle against a behavioural model of the arbitration rules.
module tb_packet_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DB = 8;
    localparam int unsigned W  = DB * 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     v, s, e, rdy;
    logic [N*W-1:0]   pkt;
    logic [N*DB-1:0]  be;
    logic             o_valid, o_sop, o_eop, o_perr;
    logic [W-1:0]     o_pkt;
    logic [DB-1:0]    o_be;
    logic [1:0]       o_port;
    logic [15:0]      o_drop;

    always #5 clk = ~clk;

    packet_arbiter #(.N_PORTS(N), .DATA_BYTES(DB)) dut (
        .iClk(clk), .iReset(rst),
        .iValid(v), .iPacket(pkt), .iSop(s), .iEop(e), .iByte_enable(be),
        .oReady(rdy), .oValid(o_valid), .oPacket(o_pkt), .oSop(o_sop),
        .oEop(o_eop), .oByte_enable(o_be), .oPort(o_port),
        .oProto_err(o_perr), .oDrop_count(o_drop)
    );

    int total = 0;
    int bad   = 0;

    // Model state: what the output register should hold, and the arbiter view.
    bit          m_known = 1'b0;
    bit          m_busy;
    int          m_owner, m_last, m_drop;
    bit          x_valid, x_sop, x_eop, x_perr;
    logic [W-1:0]  x_pkt;
    logic [DB-1:0] x_be;
    int          x_port;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        v = '0; s = '0; e = '0;
    endtask

    task automatic put(input int p, input bit vv, input bit ss, input bit ee, input logic [7:0] bb);
        v[p] = vv; s[p] = ss; e[p] = ee;
        be[p*DB +: DB] = bb;
        pkt[p*W +: W]  = {$urandom, $urandom};
    endtask

    // Inputs are already applied; check, advance the model, go to next negedge.
    task automatic cycle();
        logic [N-1:0] er;
        int g, nd, sum;
        #1;
        if (m_known) begin
            check("valid", 64'(o_valid), 64'(x_valid));
            check("proto_err", 64'(o_perr), 64'(x_perr));
            check("drop_count", 64'(o_drop), 64'(m_drop));
            if (x_valid) begin
                check("data", 64'(o_pkt), 64'(x_pkt));
                check("byte_en", 64'(o_be), 64'(x_be));
                check("port", 64'(o_port), 64'(x_port));
                check("sop", 64'(o_sop), 64'(x_sop));
                check("eop", 64'(o_eop), 64'(x_eop));
            end
        end
        er = '0; g = -1; nd = 0;
        if (rst) begin
            m_known = 1'b1; m_busy = 1'b0; m_owner = 0; m_last = N - 1; m_drop = 0;
            x_valid = 1'b0; x_sop = 1'b0; x_eop = 1'b0; x_perr = 1'b0;
            x_pkt = '0; x_be = '0; x_port = 0;
        end else begin
            if (!m_busy) begin
                for (int k = 1; k <= N; k++) begin
                    int p = (m_last + k) % N;
                    if (g < 0 && v[p] && s[p]) g = p;
                end
            end else if (v[m_owner]) begin
                g = m_owner;
            end
            for (int p = 0; p < N; p++) begin
                if (v[p] && !s[p] && p != g) begin
                    er[p] = 1'b1;
                    nd++;
                end
            end
            x_perr = 1'b0;
            if (g >= 0) begin
                er[g]   = 1'b1;
                x_perr  = m_busy && s[g];
                x_valid = 1'b1;
                x_sop   = s[g];
                x_eop   = e[g];
                x_pkt   = pkt[g*W +: W];
                x_be    = be[g*DB +: DB];
                x_port  = g;
                if (!m_busy) begin
                    m_last  = g;
                    m_owner = g;
                end
                m_busy = !e[g];
            end else begin
                x_valid = 1'b0;
            end
            sum    = m_drop + nd;
            m_drop = (sum > 65535) ? 65535 : sum;
        end
        check("ready", 64'(rdy), 64'(er));
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle(); rst = 1'b1; cycle(); rst = 1'b0;
    endtask

    initial begin
        pkt = '0; be = '0; idle(); rst = 1'b1;
        cycle(); rst = 1'b0;

        // single 3-beat packet on port 2
        put(2, 1, 1, 0, 8'hFF); cycle();
        put(2, 1, 0, 0, 8'hFF); cycle();
        put(2, 1, 0, 1, 8'h0F); cycle();
        idle(); cycle(); cycle();

        // contention after reset: port 0 first, port 1 holds its sop beat
        do_reset();
        put(0, 1, 1, 0, 8'h11); put(1, 1, 1, 0, 8'h22); cycle();
        put(0, 1, 0, 1, 8'h13); cycle();
        put(0, 0, 0, 0, 8'h00); cycle();
        put(1, 1, 0, 1, 8'h23); cycle();
        idle(); cycle(); cycle();

        // fairness: every port streams single-beat packets
        do_reset();
        for (int c = 0; c < 9; c++) begin
            for (int p = 0; p < N; p++) put(p, 1, 1, 1, 8'hFF);
            cycle();
        end
        idle(); cycle();

        // stray drop while idle
        do_reset();
        for (int c = 0; c < 5; c++) begin
            put(3, 1, 0, 0, 8'hFF); cycle();
        end
        idle(); cycle();
        #1; check("stray_total", 64'(o_drop), 64'd5);

        // owner stall then protocol error; port 0 waits for port 1's eop
        do_reset();
        put(1, 1, 1, 0, 8'hFF); cycle();
        for (int c = 0; c < 3; c++) begin
            put(1, 0, 0, 0, 8'h00); put(0, 1, 1, 1, 8'hAA); cycle();
        end
        put(1, 1, 1, 0, 8'hF0); cycle();
        put(1, 1, 0, 1, 8'h0F); cycle();
        put(1, 0, 0, 0, 8'h00); cycle();
        idle(); cycle(); cycle();

        // reset mid-packet, then a new sop from port 1
        do_reset();
        put(0, 1, 1, 0, 8'hFF); cycle();
        put(0, 1, 0, 0, 8'hFF); cycle();
        put(0, 1, 0, 0, 8'hFF); rst = 1'b1; cycle(); rst = 1'b0;
        idle(); put(1, 1, 1, 1, 8'h3C); cycle();
        idle(); cycle();
        #1; check("post_reset_port", 64'(o_port), 64'd1);

        // random traffic with occasional reset
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < N; p++) begin
                put(p, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
                    $urandom_range(0, 9) < 4, 8'($urandom));
            end
            rst = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst = 1'b0;

        // drop counter saturation
        do_reset();
        for (int c = 0; c < 16400; c++) begin
            for (int p = 0; p < N; p++) put(p, 1, 0, 0, 8'hFF);
            cycle();
        end
        idle(); cycle();
        #1; check("drop_saturated", 64'(o_drop), 64'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/packet_arbiter.md
# packet_arbiter

Packet-granular round-robin arbiter that merges `N_PORTS` packet streams onto the single input of `payload_aligner`. Once a port wins with a start-of-packet beat, it holds the grant until its end-of-packet beat transfers, so packets are never interleaved. The output is registered and matches the `payload_aligner` input bundle (valid, data, sop, eop, byte_enable), plus the source port index. Downstream has no backpressure; per-port `oReady` is the only flow control.

## Interface
- `N_PORTS`, 4: number of requesters, 2..8.
- `DATA_BYTES`, 8: bytes per beat; `W = DATA_BYTES*8`.
- `iClk` in 1: clock.
- `iReset` in 1: synchronous, active-high reset.
- `iValid` in N_PORTS: per-port beat valid.
- `iPacket` in N_PORTS*W: per-port data; port i at `[i*W +: W]`.
- `iSop` in N_PORTS: per-port start of packet.
- `iEop` in N_PORTS: per-port end of packet.
- `iByte_enable` in N_PORTS*DATA_BYTES: per-port byte enables; port i at `[i*DATA_BYTES +: DATA_BYTES]`.
- `oReady` out N_PORTS: beat on port i transfers when `iValid[i] && oReady[i]`. Combinational.
- `oValid` out 1: registered output beat valid; drives `payload_aligner.iValid`.
- `oPacket` out W: registered data.
- `oSop` out 1: registered start of packet.
- `oEop` out 1: registered end of packet.
- `oByte_enable` out DATA_BYTES: registered byte enables.
- `oPort` out $clog2(N_PORTS): source port of the current output beat.
- `oProto_err` out 1: one-cycle pulse when an owner presents `iSop` mid-packet.
- `oDrop_count` out 16: saturating count of discarded stray beats.

## Operation
- States:
  - ARB: no packet is in flight.
  - LOCKED: `owner` is mid-packet.
- ARB:
  - Candidates are ports with `iValid && iSop`.
  - The winner is the first candidate found scanning from `(last+1) mod N_PORTS` upward with wrap.
  - The winner is granted in the same cycle: `oReady[winner]=1` and its first beat transfers. `last` and `owner` are set to the winner.
  - If the winning beat also has `iEop`, the FSM stays in ARB. Otherwise it goes to LOCKED.
- LOCKED:
  - `oReady[owner]=1`; all other ports see `oReady=0`, except for stray draining (below).
  - A transferred owner beat with `iEop=1` returns the FSM to ARB on the next cycle.
  - If the owner drops `iValid`, the output bubbles (`oValid=0`). There is no timeout.
- Stray beats: a port with `iValid=1`, `iSop=0` that is not the current owner/winner is drained.
  - It gets `oReady=1` and the beat is discarded.
  - `oDrop_count` increments once per dropped beat, saturating at 0xFFFF.
  - Multiple strays in the same cycle add their count.
- Owner `iSop=1` while LOCKED:
  - The beat is forwarded unchanged, with sop=1, and ownership is retained.
  - `oProto_err` pulses in the output cycle of that beat.
- Losing sop candidates see `oReady=0` and must hold their beat.
- Output register: on a transfer, the next cycle shows `oValid=1` and the beat fields with `oPort=owner`. Otherwise `oValid=0` and the data fields hold their previous values.
- `last` resets to `N_PORTS-1`, so port 0 has first priority after reset.

## Timing
- Latency is 1 cycle from input transfer to the output beat.
- Throughput is 1 beat/cycle. Back-to-back packets, including from different ports, have zero bubbles: the cycle after an eop beat transfers is an ARB cycle that can grant.
- Reset values:
  - `oValid`, `oSop`, `oEop`, `oProto_err` = 0.
  - `oPacket`, `oByte_enable`, `oPort` = 0.
  - `oDrop_count` = 0.
  - State = ARB, `last = N_PORTS-1`.
  - `oReady` = 0 during the reset cycle.
- Reset mid-packet abandons the packet. No eop is emitted; the downstream aligner is reset by the same `iReset`.
- `oReady` depends combinationally on `iValid`/`iSop` and on state. Sources must not make `iValid` depend on `oReady`.

## Test plan
- **Single packet:** port 2 sends a 3-beat packet (sop, mid, eop) with `byte_enable` 0xFF, 0xFF, 0x0F.
  - `oReady[2]=1` on all three cycles.
  - Output beats appear 1 cycle later with `oPort=2`, sop/eop on the first/last beat, and `oByte_enable` 0xFF, 0xFF, 0x0F.
- **Contention after reset:** ports 0 and 1 raise sop in the same cycle, each with a 2-beat packet.
  - Port 0 is granted first.
  - Port 1 holds its beat and is granted in the cycle after port 0's eop transfers.
  - The output shows 4 contiguous valid beats.
- **Fairness:** all 4 ports stream single-beat (sop&eop) packets continuously.
  - Grant order is 0,1,2,3,0,... and `oValid` stays 1 every cycle.
- **Stray drop:** port 3 presents 5 beats with `iSop=0` while idle.
  - `oReady[3]=1` on each beat and `oValid` stays 0.
  - `oDrop_count` reaches 5.
- **Owner stall and error:** port 1 sends sop, then holds `iValid=0` for 3 cycles, then sends a beat with `iSop=1`, then an eop beat.
  - The output shows a 3-cycle bubble.
  - `oProto_err` pulses once, with the sop beat.
  - Port 0 requesting during this period is not granted until after port 1's eop.
- **Reset mid-packet:** assert `iReset` for 1 cycle after beat 2 of a 4-beat packet on port 0.
  - All outputs return to 0 and the state returns to ARB.
  - The next sop, from port 1, is granted immediately with `oPort=1`.
